// File: rtl/square_motion_ctrl.sv
// Square motion sequencer, pixel clock domain.
// Once per FRAME_DIV frame ticks it computes the next top-left position of
// the square, reflects it off the screen edges and commits the result in a
// single edge, so readers never see a half-updated position.
// Optional build macro: SQ_MOTION_PAUSE_EN adds a level-sensitive pause input
// that makes IDLE ignore frame ticks.
//
// state  | meaning
// IDLE   | waiting for a frame tick, counting frames toward FRAME_DIV
// CALC_X | compute next x, direction and edge hit into scratch registers
// CALC_Y | compute next y, direction and edge hit into scratch registers
// COMMIT | copy scratch values to the outputs, pulse bounce on any hit
module square_motion_ctrl #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int SIZE      = 50,
    parameter int SPEED     = 2,
    parameter int FRAME_DIV = 1,
    parameter int START_X   = (H_RES - SIZE) / 2,
    parameter int START_Y   = (V_RES - SIZE) / 2
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       frame_tick,
`ifdef SQ_MOTION_PAUSE_EN
    input  logic       pause,
`endif
    output logic [9:0] sq_x,
    output logic [9:0] sq_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       bounce,
    output logic       busy
);

    localparam int          CW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [10:0] X_LIM = 11'(H_RES - SIZE);
    localparam logic [10:0] Y_LIM = 11'(V_RES - SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [9:0]    sq_x_q, sq_x_d, sq_y_q, sq_y_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [9:0]    nx_q, nx_d, ny_q, ny_d;
    logic          ndx_q, ndx_d, ndy_q, ndy_d;
    logic          hit_x_q, hit_x_d, hit_y_q, hit_y_d;
    logic          bounce_q, bounce_d;
    logic          tick_ok;

`ifdef SQ_MOTION_PAUSE_EN
    assign tick_ok = frame_tick & ~pause;
`else
    assign tick_ok = frame_tick;
`endif

    // One axis step with reflection; result is {hit, new_dir, new_pos}.
    // Arithmetic is 11 bits wide so pos+SPEED never wraps near the bound.
    function automatic logic [11:0] step_axis(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [10:0] lim);
        logic [10:0] p;
        logic [10:0] s;
        p = {1'b0, pos};
        s = 11'(SPEED);
        if (dir) begin
            if (p + s >= lim) step_axis = {1'b1, 1'b0, lim[9:0]};
            else              step_axis = {1'b0, 1'b1, 10'(p + s)};
        end else begin
            if (p <= s)       step_axis = {1'b1, 1'b1, 10'd0};
            else              step_axis = {1'b0, 1'b0, 10'(p - s)};
        end
    endfunction

    // State register, committed outputs and scratch registers.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            sq_x_q      <= 10'(START_X);
            sq_y_q      <= 10'(START_Y);
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            nx_q        <= '0;
            ny_q        <= '0;
            ndx_q       <= 1'b0;
            ndy_q       <= 1'b0;
            hit_x_q     <= 1'b0;
            hit_y_q     <= 1'b0;
            bounce_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            sq_x_q      <= sq_x_d;
            sq_y_q      <= sq_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            ndx_q       <= ndx_d;
            ndy_q       <= ndy_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
            bounce_q    <= bounce_d;
        end
    end

    // Next-state logic: frame division, per-axis calculation, commit.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        sq_x_d      = sq_x_q;
        sq_y_d      = sq_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        ndx_d       = ndx_q;
        ndy_d       = ndy_q;
        hit_x_d     = hit_x_q;
        hit_y_d     = hit_y_q;
        bounce_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_ok) begin
                    if (frame_cnt_q == CNT_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = CALC_X;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            CALC_X: begin
                {hit_x_d, ndx_d, nx_d} = step_axis(sq_x_q, dir_x_q, X_LIM);
                state_d = CALC_Y;
            end
            CALC_Y: begin
                {hit_y_d, ndy_d, ny_d} = step_axis(sq_y_q, dir_y_q, Y_LIM);
                state_d = COMMIT;
            end
            COMMIT: begin
                sq_x_d   = nx_q;
                sq_y_d   = ny_q;
                dir_x_d  = ndx_q;
                dir_y_d  = ndy_q;
                bounce_d = hit_x_q | hit_y_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sq_x   = sq_x_q;
    assign sq_y   = sq_y_q;
    assign dir_x  = dir_x_q;
    assign dir_y  = dir_y_q;
    assign bounce = bounce_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Bench for square_motion_ctrl: hand-written latency sequence and a random
// run against a position/direction model on a default instance, and a
// vector table on an edge-start, FRAME_DIV=3 instance.
module tb_square_motion_ctrl;

    localparam int SPEED = 2;
    localparam int X_LIM = 590;
    localparam int Y_LIM = 430;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic       rst0, tick0, rst1, tick1;
    logic [9:0] x0, y0, x1, y1;
    logic       dx0, dy0, b0, busy0, dx1, dy1, b1, busy1;
`ifdef SQ_MOTION_PAUSE_EN
    logic       pause0, pause1;
`endif

    square_motion_ctrl u_dut0 (
        .clk_pix   (clk_pix),
        .rst_pix   (rst0),
        .frame_tick(tick0),
`ifdef SQ_MOTION_PAUSE_EN
        .pause     (pause0),
`endif
        .sq_x      (x0),
        .sq_y      (y0),
        .dir_x     (dx0),
        .dir_y     (dy0),
        .bounce    (b0),
        .busy      (busy0)
    );

    square_motion_ctrl #(
        .START_X  (588),
        .START_Y  (428),
        .FRAME_DIV(3)
    ) u_dut1 (
        .clk_pix   (clk_pix),
        .rst_pix   (rst1),
        .frame_tick(tick1),
`ifdef SQ_MOTION_PAUSE_EN
        .pause     (pause1),
`endif
        .sq_x      (x1),
        .sq_y      (y1),
        .dir_x     (dx1),
        .dir_y     (dy1),
        .bounce    (b1),
        .busy      (busy1)
    );

    typedef struct {
        logic       rst;
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic       b;
        logic       busy;
    } vec_t;

    vec_t tbl[25];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic r, logic t, int x, int y,
                                logic dx, logic dy, logic b, logic bz);
        vec_t v;
        v.rst = r; v.tick = t; v.x = 10'(x); v.y = 10'(y);
        v.dx = dx; v.dy = dy; v.b = b; v.busy = bz;
        return v;
    endfunction

    function automatic logic [31:0] pk(int x, int y, logic dx, logic dy,
                                       logic b, logic bz);
        return {8'd0, 10'(x), 10'(y), dx, dy, b, bz};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (x,y,dx,dy,bounce,busy packed)",
                      name, act, exp);
    endtask

    // Move one axis by SPEED in its direction; landing on or past an edge
    // clamps to that edge, flips direction and reports a hit.
    task automatic ref_step(inout int pos, inout int dir, output bit hit,
                            input int lim);
        int np;
        hit = 1'b0;
        np  = (dir != 0) ? pos + SPEED : pos - SPEED;
        if (np >= lim) begin
            np = lim; dir = 0; hit = 1'b1;
        end else if (np <= 0) begin
            np = 0; dir = 1; hit = 1'b1;
        end
        pos = np;
    endtask

    initial begin
        int mx, my, mdx, mdy, phase;
        bit mb, hx, hy, t, r;

        tbl[0]  = mk(1, 0, 588, 428, 1, 1, 0, 0);
        tbl[1]  = mk(1, 0, 588, 428, 1, 1, 0, 0);
        tbl[2]  = mk(0, 1, 588, 428, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 588, 428, 1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 588, 428, 1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 588, 428, 1, 1, 0, 0);
        tbl[6]  = mk(0, 1, 588, 428, 1, 1, 0, 1);
        tbl[7]  = mk(0, 1, 588, 428, 1, 1, 0, 1);
        tbl[8]  = mk(0, 0, 588, 428, 1, 1, 0, 1);
        tbl[9]  = mk(0, 0, 590, 430, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 590, 430, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 590, 430, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 590, 430, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 590, 430, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 590, 430, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 590, 430, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 590, 430, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 590, 430, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 588, 428, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 588, 428, 0, 0, 0, 0);
        tbl[20] = mk(0, 1, 588, 428, 0, 0, 0, 0);
        tbl[21] = mk(0, 1, 588, 428, 0, 0, 0, 1);
        tbl[22] = mk(0, 0, 588, 428, 0, 0, 0, 1);
        tbl[23] = mk(1, 0, 588, 428, 1, 1, 0, 0);
        tbl[24] = mk(0, 0, 588, 428, 1, 1, 0, 0);

        rst0 = 1'b1; tick0 = 1'b0; rst1 = 1'b1; tick1 = 1'b0;
`ifdef SQ_MOTION_PAUSE_EN
        pause0 = 1'b0; pause1 = 1'b0;
`endif
        repeat (2) @(negedge clk_pix);
        rst0 = 1'b0;
        check("reset", {8'd0, x0, y0, dx0, dy0, b0, busy0}, pk(295, 215, 1, 1, 0, 0));

        // Single update latency: busy for exactly three cycles, then commit.
        tick0 = 1'b1;
        @(negedge clk_pix);
        tick0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("busy_window", {8'd0, x0, y0, dx0, dy0, b0, busy0},
                  pk(295, 215, 1, 1, 0, 1));
            @(negedge clk_pix);
        end
        check("first_commit", {8'd0, x0, y0, dx0, dy0, b0, busy0}, pk(297, 217, 1, 1, 0, 0));
        @(negedge clk_pix);
        check("after_commit", {8'd0, x0, y0, dx0, dy0, b0, busy0}, pk(297, 217, 1, 1, 0, 0));

`ifdef SQ_MOTION_PAUSE_EN
        pause0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick0 = 1'b1;
            @(negedge clk_pix);
            tick0 = 1'b0;
            repeat (3) @(negedge clk_pix);
        end
        check("pause_hold", {8'd0, x0, y0, dx0, dy0, b0, busy0}, pk(297, 217, 1, 1, 0, 0));
        pause0 = 1'b0;
`endif

        // Random ticks (including ticks while busy) and rare resets.
        mx = 297; my = 217; mdx = 1; mdy = 1; mb = 1'b0; phase = 0;
        for (int c = 0; c < 15000; c++) begin
            t = ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 5999) == 0);
            tick0 = t;
            rst0  = r;
            @(negedge clk_pix);
            if (r) begin
                mx = 295; my = 215; mdx = 1; mdy = 1; mb = 1'b0; phase = 0;
            end else begin
                mb = 1'b0;
                if (phase == 0) begin
                    if (t) phase = 1;
                end else if (phase < 3) begin
                    phase++;
                end else begin
                    ref_step(mx, mdx, hx, X_LIM);
                    ref_step(my, mdy, hy, Y_LIM);
                    mb = hx | hy;
                    phase = 0;
                end
            end
            check("random", {8'd0, x0, y0, dx0, dy0, b0, busy0},
                  pk(mx, my, mdx[0], mdy[0], mb, phase != 0));
        end
        tick0 = 1'b0;
        rst0  = 1'b0;

        // Edge start, FRAME_DIV=3, ignored tick while busy, reset in CALC_Y.
        for (int i = 0; i < 25; i++) begin
            rst1  = tbl[i].rst;
            tick1 = tbl[i].tick;
            @(negedge clk_pix);
            check($sformatf("vec%0d", i), {8'd0, x1, y1, dx1, dy1, b1, busy1},
                  pk(int'(tbl[i].x), int'(tbl[i].y), tbl[i].dx, tbl[i].dy,
                     tbl[i].b, tbl[i].busy));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
